// File: rtl/sub_sub_d_ser_if.sv
// Handshake and serial-output bundle between an upstream word source and sub_sub_d_ser.
// master drives words in; slave is the serialiser.
interface sub_sub_d_ser_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] testi1_sub_data;
  logic             testi1_sub_valid;
  logic             testo1_sub_ready;
  logic             testo1_sub_d;
  logic             testo1_sub_clk_d;
  logic             testo1_sub_busy;
  logic             testo1_sub_done;

  modport master (
    output testi1_sub_data,
    output testi1_sub_valid,
    input  testo1_sub_ready,
    input  testo1_sub_d,
    input  testo1_sub_clk_d,
    input  testo1_sub_busy,
    input  testo1_sub_done
  );

  modport slave (
    input  testi1_sub_data,
    input  testi1_sub_valid,
    output testo1_sub_ready,
    output testo1_sub_d,
    output testo1_sub_clk_d,
    output testo1_sub_busy,
    output testo1_sub_done
  );
endinterface

// File: rtl/sub_sub_d_ser.sv
// sub_sub_d_ser: serialises a word as SETUP/GATE/HOLD bit slots for a downstream latch.
// Build macro SUB_SUB_D_PARITY_EN appends an even-parity bit after the data bits.
module sub_sub_d_ser #(
  parameter int WIDTH       = 8,
  parameter int GATE_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic           testi1_sub_clk,
  input  logic           testi1_sub_rst,
  sub_sub_d_ser_if.slave bus
);
`ifdef SUB_SUB_D_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] GATE  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             ser_q, ser_d;
  logic             gate_q, gate_d;
  logic             done_q, done_d;
  logic             accept;
  logic [NBITS-1:0] load_word;

  assign accept = bus.testi1_sub_valid && (state_q == IDLE);

`ifdef SUB_SUB_D_PARITY_EN
  // Parity sits in the slot that is shifted out last, whichever end that is.
  generate
    if (MSB_FIRST) begin : g_load_msb
      assign load_word = {bus.testi1_sub_data, ^bus.testi1_sub_data};
    end else begin : g_load_lsb
      assign load_word = {^bus.testi1_sub_data, bus.testi1_sub_data};
    end
  endgenerate
`else
  assign load_word = bus.testi1_sub_data;
`endif

  function automatic logic head_bit(input logic [NBITS-1:0] s);
    return MSB_FIRST ? s[NBITS-1] : s[0];
  endfunction

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          shreg_d = load_word;
          cnt_d   = CW'(NBITS);
        end
      end
      SETUP: begin
        state_d = GATE;
        gcnt_d  = GW'(GATE_CYCLES - 1);
      end
      GATE: begin
        if (gcnt_q == '0) begin
          state_d = HOLD;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
          done_d  = 1'b1;
        end else begin
          // The only point where the presented bit advances.
          state_d = SETUP;
          cnt_d   = cnt_q - 1'b1;
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end
      end
      default: state_d = IDLE;
    endcase
    gate_d = (state_d == GATE);
    ser_d  = (state_d == IDLE) ? 1'b0 : head_bit(shreg_d);
  end

  always_ff @(posedge testi1_sub_clk or posedge testi1_sub_rst) begin
    if (testi1_sub_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ser_q   <= 1'b0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      ser_q   <= ser_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
    end
  end

  assign bus.testo1_sub_ready = (state_q == IDLE);
  assign bus.testo1_sub_busy  = (state_q != IDLE);
  assign bus.testo1_sub_d     = ser_q;
  assign bus.testo1_sub_clk_d = gate_q;
  assign bus.testo1_sub_done  = done_q;
endmodule
